id_stage_pipe: RTL and testbench

// Parametrised decode stage with an integrated ID/EX pipeline register. It decodes one

---
 rtl/id_stage_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with integrated ID/EX pipeline register.
// Decodes one instruction per cycle and tracks pending register writes in
// a scoreboard. A RAW hazard against the scoreboard stalls the stage
// internally. Valid/ready handshakes are used on both the upstream and
// downstream sides.
// Optional feature: define ID_WB_BYPASS_EN to add the wb_data port and
// forward a same-cycle write-back into the rs/rt operands.
module id_stage_pipe #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            inst,
    input  logic [DATA_W-1:0]      rs_data,
    input  logic [DATA_W-1:0]      rt_data,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_dst,
`ifdef ID_WB_BYPASS_EN
    input  logic [DATA_W-1:0]      wb_data,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_a,
    output logic [DATA_W-1:0]      out_b,
    output logic [DATA_W-1:0]      out_imm,
    output logic [REG_ADDR_W-1:0]  out_dst,
    output logic                   out_reg_write,
    output logic                   out_mem_read,
    output logic                   out_mem_write,
    output logic                   out_mem_to_reg,
    output logic                   out_halted,
    output logic [3:0]             out_alu_ctrl,
    output logic                   hazard,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned NREG = 1 << REG_ADDR_W;
    localparam logic [5:0]  FUNC_HALT = 6'b001100;

    typedef enum logic [2:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNC,
        ALUOP_AND,
        ALUOP_OR,
        ALUOP_SLT,
        ALUOP_LUI
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SRL = 4'b0100,
        ALU_SRA = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_LUI = 4'b1000,
        ALU_NOR = 4'b1100,
        ALU_XOR = 4'b1101
    } alu_ctrl_e;

    // Map a 5-bit instruction register field onto REG_ADDR_W bits
    // (truncate when narrower, zero-extend when wider).
    function automatic logic [REG_ADDR_W-1:0] reg_idx(input logic [4:0] f);
        logic [REG_ADDR_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < REG_ADDR_W; i++) begin
            if (i < 5) r[i] = f[i];
        end
        return r;
    endfunction

    // Instruction fields
    logic [5:0]            opcode;
    logic [5:0]            func;
    logic [4:0]            shamt;
    logic [15:0]           imm16;
    logic [REG_ADDR_W-1:0] rs_idx;
    logic [REG_ADDR_W-1:0] rt_idx;
    logic [REG_ADDR_W-1:0] rd_idx;

    assign opcode = inst[31:26];
    assign rs_idx = reg_idx(inst[25:21]);
    assign rt_idx = reg_idx(inst[20:16]);
    assign rd_idx = reg_idx(inst[15:11]);
    assign shamt  = inst[10:6];
    assign imm16  = inst[15:0];
    assign func   = inst[5:0];

    // Control unit outputs
    logic       ctl_reg_dst;
    logic [1:0] ctl_alu_src;
    logic       ctl_do_extend;
    logic       ctl_reg_write;
    logic       ctl_mem_read;
    logic       ctl_mem_write;
    logic       ctl_mem_to_reg;
    logic       ctl_halted;
    logic       ctl_src1;
    logic       ctl_src2;
    alu_op_e    ctl_alu_op;
    alu_ctrl_e  alu_ctrl;

    // Registered state
    logic                   out_valid_q;
    logic [DATA_W-1:0]      out_a_q;
    logic [DATA_W-1:0]      out_b_q;
    logic [DATA_W-1:0]      out_imm_q;
    logic [REG_ADDR_W-1:0]  out_dst_q;
    logic                   out_reg_write_q;
    logic                   out_mem_read_q;
    logic                   out_mem_write_q;
    logic                   out_mem_to_reg_q;
    logic                   out_halted_q;
    logic [3:0]             out_alu_ctrl_q;
    logic                   halt_q;
    logic [NREG-1:0]        pend_q;
    logic [NREG-1:0]        pend_d;
    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W-1:0] stall_d;

    // Decode datapath
    logic [DATA_W-1:0]     rs_val;
    logic [DATA_W-1:0]     rt_val;
    logic [DATA_W-1:0]     dec_imm;
    logic [DATA_W-1:0]     dec_a;
    logic [DATA_W-1:0]     dec_b;
    logic [REG_ADDR_W-1:0] dec_dst;
    logic                  dec_reg_write;
    logic                  rs_pend;
    logic                  rt_pend;
    logic                  accept;

    // Main control: opcode/func to datapath control bits
    always_comb begin
        ctl_reg_dst    = 1'b0;
        ctl_alu_src    = 2'b00;
        ctl_do_extend  = 1'b0;
        ctl_reg_write  = 1'b0;
        ctl_mem_read   = 1'b0;
        ctl_mem_write  = 1'b0;
        ctl_mem_to_reg = 1'b0;
        ctl_src1       = 1'b0;
        ctl_src2       = 1'b0;
        ctl_alu_op     = ALUOP_ADD;
        ctl_halted     = (opcode == 6'h00) && (func == FUNC_HALT);
        case (opcode)
            6'h00: begin
                if (func != FUNC_HALT) begin
                    ctl_reg_dst   = 1'b1;
                    ctl_reg_write = 1'b1;
                    ctl_alu_op    = ALUOP_FUNC;
                    ctl_src2      = 1'b1;
                    // Shifts take shamt as operand a and do not read rs
                    if (func == 6'h00 || func == 6'h02 || func == 6'h03) begin
                        ctl_alu_src[0] = 1'b1;
                    end else begin
                        ctl_src1 = 1'b1;
                    end
                end
            end
            6'h08, 6'h09: begin // addi, addiu
                ctl_alu_src   = 2'b10;
                ctl_do_extend = 1'b1;
                ctl_reg_write = 1'b1;
                ctl_src1      = 1'b1;
            end
            6'h0A: begin // slti
                ctl_alu_src   = 2'b10;
                ctl_do_extend = 1'b1;
                ctl_reg_write = 1'b1;
                ctl_src1      = 1'b1;
                ctl_alu_op    = ALUOP_SLT;
            end
            6'h0C: begin // andi
                ctl_alu_src   = 2'b10;
                ctl_reg_write = 1'b1;
                ctl_src1      = 1'b1;
                ctl_alu_op    = ALUOP_AND;
            end
            6'h0D: begin // ori
                ctl_alu_src   = 2'b10;
                ctl_reg_write = 1'b1;
                ctl_src1      = 1'b1;
                ctl_alu_op    = ALUOP_OR;
            end
            6'h0F: begin // lui
                ctl_alu_src   = 2'b10;
                ctl_reg_write = 1'b1;
                ctl_alu_op    = ALUOP_LUI;
            end
            6'h23: begin // lw
                ctl_alu_src    = 2'b10;
                ctl_do_extend  = 1'b1;
                ctl_reg_write  = 1'b1;
                ctl_mem_read   = 1'b1;
                ctl_mem_to_reg = 1'b1;
                ctl_src1       = 1'b1;
            end
            6'h2B: begin // sw
                ctl_alu_src   = 2'b10;
                ctl_do_extend = 1'b1;
                ctl_mem_write = 1'b1;
                ctl_src1      = 1'b1;
                ctl_src2      = 1'b1;
            end
            6'h04, 6'h05: begin // beq, bne
                ctl_do_extend = 1'b1;
                ctl_src1      = 1'b1;
                ctl_src2      = 1'b1;
                ctl_alu_op    = ALUOP_SUB;
            end
            default: ;
        endcase
    end

    // ALU control: alu_op plus func field to ALU operation code
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (ctl_alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_AND: alu_ctrl = ALU_AND;
            ALUOP_OR:  alu_ctrl = ALU_OR;
            ALUOP_SLT: alu_ctrl = ALU_SLT;
            ALUOP_LUI: alu_ctrl = ALU_LUI;
            ALUOP_FUNC: begin
                case (func)
                    6'h00:        alu_ctrl = ALU_SLL;
                    6'h02:        alu_ctrl = ALU_SRL;
                    6'h03:        alu_ctrl = ALU_SRA;
                    6'h20, 6'h21: alu_ctrl = ALU_ADD;
                    6'h22, 6'h23: alu_ctrl = ALU_SUB;
                    6'h24:        alu_ctrl = ALU_AND;
                    6'h25:        alu_ctrl = ALU_OR;
                    6'h26:        alu_ctrl = ALU_XOR;
                    6'h27:        alu_ctrl = ALU_NOR;
                    6'h2A:        alu_ctrl = ALU_SLT;
                    default:      alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    // Operand sourcing, hazard detection and handshake
    always_comb begin
        rs_val  = rs_data;
        rt_val  = rt_data;
        rs_pend = pend_q[rs_idx];
        rt_pend = pend_q[rt_idx];
`ifdef ID_WB_BYPASS_EN
        // A retiring write to a source register both supplies the value and
        // resolves the dependency in the same cycle; r0 is never forwarded.
        if (wb_valid && (wb_dst != '0) && (wb_dst == rs_idx)) begin
            rs_val  = wb_data;
            rs_pend = 1'b0;
        end
        if (wb_valid && (wb_dst != '0) && (wb_dst == rt_idx)) begin
            rt_val  = wb_data;
            rt_pend = 1'b0;
        end
`endif
        dec_imm       = ctl_do_extend ? DATA_W'($signed(imm16)) : DATA_W'(imm16);
        dec_a         = ctl_alu_src[0] ? DATA_W'(shamt) : rs_val;
        dec_b         = ctl_alu_src[1] ? dec_imm : rt_val;
        dec_dst       = ctl_reg_dst ? rd_idx : rt_idx;
        dec_reg_write = ctl_reg_write && (dec_dst != '0);
        hazard        = in_valid && ((ctl_src1 && rs_pend) || (ctl_src2 && rt_pend));
        in_ready      = !halt_q && !flush && !hazard && (!out_valid_q || out_ready);
        accept        = in_valid && in_ready;
    end

    // Scoreboard and stall-counter next state; set is applied last so it
    // wins over a same-cycle clear of the same register
    always_comb begin
        pend_d = pend_q;
        if (wb_valid) pend_d[wb_dst] = 1'b0;
        if (flush && out_valid_q && out_reg_write_q) pend_d[out_dst_q] = 1'b0;
        if (accept && dec_reg_write) pend_d[dec_dst] = 1'b1;
        pend_d[0] = 1'b0;

        stall_d = stall_q;
        if (hazard && !flush && (stall_q != '1)) stall_d = stall_q + STALL_CNT_W'(1);
    end

    // ID/EX register, halt latch, scoreboard and stall counter
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid_q      <= 1'b0;
            out_a_q          <= '0;
            out_b_q          <= '0;
            out_imm_q        <= '0;
            out_dst_q        <= '0;
            out_reg_write_q  <= 1'b0;
            out_mem_read_q   <= 1'b0;
            out_mem_write_q  <= 1'b0;
            out_mem_to_reg_q <= 1'b0;
            out_halted_q     <= 1'b0;
            out_alu_ctrl_q   <= '0;
            halt_q           <= 1'b0;
            pend_q           <= '0;
            stall_q          <= '0;
        end else begin
            pend_q  <= pend_d;
            stall_q <= stall_d;
            if (flush) begin
                out_valid_q <= 1'b0;
                halt_q      <= 1'b0;
            end else if (accept) begin
                out_valid_q      <= 1'b1;
                out_a_q          <= dec_a;
                out_b_q          <= dec_b;
                out_imm_q        <= dec_imm;
                out_dst_q        <= dec_dst;
                out_reg_write_q  <= dec_reg_write;
                out_mem_read_q   <= ctl_mem_read;
                out_mem_write_q  <= ctl_mem_write;
                out_mem_to_reg_q <= ctl_mem_to_reg;
                out_halted_q     <= ctl_halted;
                out_alu_ctrl_q   <= alu_ctrl;
                if (ctl_halted) halt_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_a          = out_a_q;
    assign out_b          = out_b_q;
    assign out_imm        = out_imm_q;
    assign out_dst        = out_dst_q;
    assign out_reg_write  = out_reg_write_q;
    assign out_mem_read   = out_mem_read_q;
    assign out_mem_write  = out_mem_write_q;
    assign out_mem_to_reg = out_mem_to_reg_q;
    assign out_halted     = out_halted_q;
    assign out_alu_ctrl   = out_alu_ctrl_q;
    assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode vector table plus hand-written
// sequences for stalls, backpressure, flush, halt and counter saturation.
module tb_id_stage_pipe;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SW = 4;

    localparam logic [31:0] RS = 32'h1234_5678;
    localparam logic [31:0] RT = 32'h9ABC_DEF0;
    localparam logic [31:0] WB = 32'hCAFE_F00D;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   inst = '0;
    logic [DW-1:0] rs_data = RS;
    logic [DW-1:0] rt_data = RT;
    logic          flush = 1'b0;
    logic          wb_valid = 1'b0;
    logic [AW-1:0] wb_dst = '0;
`ifdef ID_WB_BYPASS_EN
    logic [DW-1:0] wb_data = WB;
`endif
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_a, out_b, out_imm;
    logic [AW-1:0] out_dst;
    logic          out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_halted;
    logic [3:0]    out_alu_ctrl;
    logic          hazard;
    logic [SW-1:0] stall_cycles;

    int total = 0;
    int bad = 0;

    id_stage_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .wb_valid(wb_valid), .wb_dst(wb_dst),
`ifdef ID_WB_BYPASS_EN
        .wb_data(wb_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_imm(out_imm), .out_dst(out_dst), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_to_reg(out_mem_to_reg), .out_halted(out_halted),
        .out_alu_ctrl(out_alu_ctrl), .hazard(hazard), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [8:0]  ctrl; // {reg_write, mem_read, mem_write, mem_to_reg, halted, alu_ctrl}
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] im);
        return {op, 5'(rs), 5'(rt), im};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        wb_valid = 1'b0;
        out_ready = 1'b1;
        rs_data = RS;
        rt_data = RT;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    function automatic logic [8:0] ctrl_now();
        return {out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_halted, out_alu_ctrl};
    endfunction

    initial begin
        int cnt;

        vecs[0] = '{itype(6'h08, 0, 2, 16'hFFFF),   RS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  9'b1_0000_0010};
        vecs[1] = '{rtype(1, 4, 3, 0, 6'h20),       RS, RT,            32'h0000_1820, 5'd3,  9'b1_0000_0010};
        vecs[2] = '{rtype(5, 6, 7, 0, 6'h22),       RS, RT,            32'h0000_3822, 5'd7,  9'b1_0000_0110};
        vecs[3] = '{rtype(0, 9, 8, 5, 6'h00),       32'd5, RT,         32'h0000_4140, 5'd8,  9'b1_0000_0011};
        vecs[4] = '{itype(6'h23, 11, 10, 16'h8004), RS, 32'hFFFF_8004, 32'hFFFF_8004, 5'd10, 9'b1_1010_0010};
        vecs[5] = '{itype(6'h2B, 13, 12, 16'h0004), RS, 32'h0000_0004, 32'h0000_0004, 5'd12, 9'b0_0100_0010};
        vecs[6] = '{itype(6'h0D, 15, 14, 16'h8001), RS, 32'h0000_8001, 32'h0000_8001, 5'd14, 9'b1_0000_0001};
        vecs[7] = '{itype(6'h04, 1, 2, 16'hFFFE),   RS, RT,            32'hFFFF_FFFE, 5'd2,  9'b0_0000_0110};
        vecs[8] = '{rtype(1, 1, 0, 0, 6'h20),       RS, RT,            32'h0000_0020, 5'd0,  9'b0_0000_0010};
        vecs[9] = '{rtype(17, 18, 16, 0, 6'h2A),    RS, RT,            32'h0000_802A, 5'd16, 9'b1_0000_0111};

        // Reset state, sampled while reset is held
        rst_b = 1'b0;
        #3;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_a", out_a, 0);
        chk("rst out_b", out_b, 0);
        chk("rst out_imm", out_imm, 0);
        chk("rst out_dst", out_dst, 0);
        chk("rst ctrl", ctrl_now(), 0);
        chk("rst stall", stall_cycles, 0);
        do_reset();
        #1;
        chk("post-rst in_ready", in_ready, 1);
        chk("post-rst hazard", hazard, 0);

        // Decode table: accept, check registered entry, retire its destination
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            inst = vecs[i].inst;
            wb_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            wb_valid = 1'b1;
            wb_dst = vecs[i].dst;
            #1;
            chk($sformatf("vec%0d out_valid", i), out_valid, 1);
            chk($sformatf("vec%0d out_a", i), out_a, vecs[i].a);
            chk($sformatf("vec%0d out_b", i), out_b, vecs[i].b);
            chk($sformatf("vec%0d out_imm", i), out_imm, vecs[i].imm);
            chk($sformatf("vec%0d out_dst", i), out_dst, vecs[i].dst);
            chk($sformatf("vec%0d ctrl", i), ctrl_now(), vecs[i].ctrl);
            tick();
            wb_valid = 1'b0;
        end

        // RAW stall on r2, released by write-back
        do_reset();
        in_valid = 1'b1;
        inst = itype(6'h08, 0, 2, 16'hFFFF);
        tick();
        inst = rtype(2, 2, 3, 0, 6'h20);
        #1;
        chk("raw first out_imm", out_imm, 32'hFFFF_FFFF);
        chk("raw first out_dst", out_dst, 2);
        chk("raw hazard", hazard, 1);
        chk("raw in_ready", in_ready, 0);
        tick();
        tick();
        tick();
        wb_valid = 1'b1;
        wb_dst = 5'd2;
`ifdef ID_WB_BYPASS_EN
        #1;
        chk("raw wb-cycle hazard", hazard, 0);
        chk("raw wb-cycle in_ready", in_ready, 1);
        tick();
        wb_valid = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("raw stall count", stall_cycles, 3);
        chk("raw issue out_valid", out_valid, 1);
        chk("raw bypass out_a", out_a, WB);
        chk("raw bypass out_b", out_b, WB);
`else
        #1;
        chk("raw wb-cycle hazard", hazard, 1);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("raw release hazard", hazard, 0);
        chk("raw release in_ready", in_ready, 1);
        chk("raw stall count", stall_cycles, 4);
        tick();
        in_valid = 1'b0;
        #1;
        chk("raw issue out_valid", out_valid, 1);
        chk("raw issue out_a", out_a, RS);
        chk("raw issue out_b", out_b, RT);
`endif
        chk("raw issue out_dst", out_dst, 3);
        tick();

        // Backpressure: entry held for 3 cycles, next accepted when out_ready rises
        do_reset();
        in_valid = 1'b1;
        out_ready = 1'b0;
        inst = itype(6'h08, 0, 4, 16'h0011);
        tick();
        inst = itype(6'h08, 0, 5, 16'h0022);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d in_ready", c), in_ready, 0);
            chk($sformatf("bp%0d out_valid", c), out_valid, 1);
            chk($sformatf("bp%0d out_imm", c), out_imm, 32'h11);
            chk($sformatf("bp%0d out_dst", c), out_dst, 4);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp second out_imm", out_imm, 32'h22);
        chk("bp second out_dst", out_dst, 5);

        // Flush of a pending r5 entry
        flush = 1'b1;
        #1;
        chk("flush in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b1;
        inst = rtype(5, 5, 6, 0, 6'h20);
        #1;
        chk("flush out_valid", out_valid, 0);
        chk("flush r5 hazard", hazard, 0);
        chk("flush r5 in_ready", in_ready, 1);
        tick();
        inst = rtype(4, 0, 7, 0, 6'h20);
        #1;
        chk("flush r6 out_dst", out_dst, 6);
        chk("r4 still pending", hazard, 1);
        // Flush plus write-back to the same register, hazard cycle not counted
        flush = 1'b1;
        wb_valid = 1'b1;
        wb_dst = 5'd6;
        tick();
        flush = 1'b0;
        wb_valid = 1'b0;
        inst = rtype(6, 6, 7, 0, 6'h20);
        #1;
        chk("flush+wb r6 hazard", hazard, 0);
        chk("flush hazard not counted", stall_cycles, 0);
        tick();
        in_valid = 1'b0;

        // Halt is sticky until flush
        do_reset();
        in_valid = 1'b1;
        inst = rtype(0, 0, 0, 0, 6'h0C);
        tick();
        inst = itype(6'h08, 0, 9, 16'h0001);
        #1;
        chk("halt out_halted", out_halted, 1);
        chk("halt out_reg_write", out_reg_write, 0);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (in_ready) cnt++;
            tick();
        end
        chk("halt in_ready cycles", cnt, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("after halt flush in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("after halt out_dst", out_dst, 9);
        chk("after halt out_halted", out_halted, 0);

        // Write to r0 then a reader of r0
        do_reset();
        in_valid = 1'b1;
        inst = rtype(1, 1, 0, 0, 6'h20);
        tick();
        inst = rtype(0, 0, 10, 0, 6'h20);
        #1;
        chk("r0 out_reg_write", out_reg_write, 0);
        chk("r0 reader hazard", hazard, 0);
        chk("r0 reader in_ready", in_ready, 1);
        tick();

        // Stall counter saturation at 4'hF
        inst = itype(6'h08, 0, 2, 16'h0001);
        tick();
        inst = rtype(2, 2, 3, 0, 6'h20);
        repeat (14) tick();
        chk("stall 14", stall_cycles, 14);
        tick();
        chk("stall 15", stall_cycles, 15);
        repeat (5) tick();
        chk("stall saturated", stall_cycles, 15);

        // Asynchronous reset mid-operation
        #2;
        rst_b = 1'b0;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst stall", stall_cycles, 0);
        chk("async rst hazard", hazard, 0);
        in_valid = 1'b0;
        tick();
        rst_b = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
